// File: rtl/alu_addsub_arbiter.sv
// Round-robin arbiter sharing one adder_substractor among NUM_REQ requesters.
// One request in flight at a time; the result comes back on a valid/ready channel.
module alu_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*WIDTH-1:0] req_op2,
  input  logic [NUM_REQ-1:0]       req_mode,
  output logic [WIDTH-1:0]         as_op1,
  output logic [WIDTH-1:0]         as_op2,
  output logic                     as_mode,
  input  logic [2*WIDTH-1:0]       as_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*WIDTH-1:0]       rsp_result,
  output logic [ID_W-1:0]          rsp_id
);

  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   ptr_nxt;
  logic              found;

  // Search from the pointer upward, wrapping, for the first valid requester.
  always_comb begin
    int unsigned cand;
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = (32'(ptr) + k) % NR;
      if (!found && req_valid[ID_W'(cand)]) begin
        found  = 1'b1;
        winner = ID_W'(cand);
      end
    end
    ptr_nxt = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    req_ready = '0;
    // Held low throughout reset even though the state register reads IDLE.
    if (rst_n && (state == IDLE) && found)
      req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cur_id     <= '0;
      as_op1     <= '0;
      as_op2     <= '0;
      as_mode    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            as_op1  <= req_op1[int'(winner)*WIDTH +: WIDTH];
            as_op2  <= req_op2[int'(winner)*WIDTH +: WIDTH];
            as_mode <= req_mode[winner];
            cur_id  <= winner;
            ptr     <= ptr_nxt;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= as_result;
          rsp_id     <= cur_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_addsub_arbiter.sv
// Bench for alu_addsub_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_alu_addsub_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_op1;
  logic [N*W-1:0]    req_op2;
  logic [N-1:0]      req_mode;
  logic [W-1:0]      as_op1;
  logic [W-1:0]      as_op2;
  logic              as_mode;
  logic [2*W-1:0]    as_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*W-1:0]    rsp_result;
  logic [IW-1:0]     rsp_id;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared adder_substractor.
  assign as_result = as_mode ? (32'($signed(as_op1)) - 32'($signed(as_op2)))
                             : (32'($signed(as_op1)) + 32'($signed(as_op2)));

  alu_addsub_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_mode(req_mode),
    .as_op1(as_op1), .as_op2(as_op2), .as_mode(as_mode), .as_result(as_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_id(rsp_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic m);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    return m ? 32'(x - y) : 32'(x + y);
  endfunction

  // Transaction model: one job at a time, result due two cycles after its grant.
  int           cyc = 0;
  bit           busy = 0;
  int           gcyc = 0;
  int           ptr = 0;
  int           eid = 0;
  logic [31:0]  eres = '0;
  logic [W-1:0] eop1 = '0, eop2 = '0;
  logic         emode = 1'b0;
  logic [N-1:0] last_grant = '0;
  int           obs_log[$];
  int           dut_rsp_cnt[N];
  bit           hold_valid = 0;

  initial for (int i = 0; i < N; i++) dut_rsp_cnt[i] = 0;

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    bit           exp_v;
    int           w;
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_as", {as_op1, as_op2, as_mode}, 0);
      busy = 0; ptr = 0; last_grant = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (req_ready[i] && req_valid[i]) obs_log.push_back(i);
      if (rsp_valid && rsp_ready) dut_rsp_cnt[rsp_id]++;
      exp_ready = '0;
      w = -1;
      if (!busy)
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
      if (w >= 0) exp_ready[w] = 1'b1;
      exp_v = busy && (cyc >= gcyc + 2);
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        check("rsp_result", rsp_result, eres);
        check("rsp_id", rsp_id, eid);
      end
      if (busy && cyc == gcyc + 1)
        check("as_operands", {as_op1, as_op2, as_mode}, {eop1, eop2, emode});
      if (w >= 0) begin
        busy  = 1;
        gcyc  = cyc;
        eid   = w;
        eop1  = req_op1[w*W +: W];
        eop2  = req_op2[w*W +: W];
        emode = req_mode[w];
        eres  = ref_res(eop1, eop2, emode);
        ptr   = (w + 1) % N;
      end else if (exp_v && rsp_ready) begin
        busy = 0;
      end
      last_grant = exp_ready;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!hold_valid) req_valid = req_valid & ~last_grant;
  endtask

  task automatic set_req(input int i, input int a, input int b, input bit m);
    req_op1[i*W +: W] = W'(a);
    req_op2[i*W +: W] = W'(b);
    req_mode[i]       = m;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] er, input int id);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        check({tag, "_result"}, rsp_result, er);
        check({tag, "_id"}, rsp_id, id);
      end
      step();
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_grants(input int target);
    for (int i = 0; i < 80 && obs_log.size() < target; i++) step();
  endtask

  initial begin
    int base, cnt1, r_id;
    logic [31:0] r_res;
    rst_n = 1'b0; req_valid = '0; req_op1 = '0; req_op2 = '0; req_mode = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single add and signed extremes
    set_req(0, 100, -30, 1'b0);
    wait_rsp("add", 32'd70, 0);
    set_req(2, -32768, 32767, 1'b1);
    wait_rsp("sub_ext", 32'hFFFF_0001, 2);
    set_req(2, 32767, 32767, 1'b0);
    wait_rsp("add_ext", 32'd65534, 2);

    // Round robin from a fresh pointer
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    hold_valid = 1;
    for (int i = 0; i < N; i++) set_req(i, 10 * (i + 1), i, i[0]);
    base = obs_log.size();
    wait_grants(base + 5);
    req_valid = '0;
    hold_valid = 0;
    check("rr_count", obs_log.size(), base + 5);
    if (obs_log.size() >= base + 5)
      for (int j = 0; j < 5; j++) check("rr_order", obs_log[base + j], j % N);
    set_req(0, 1, 2, 1'b0);
    set_req(3, 3, 4, 1'b1);
    wait_grants(base + 7);
    check("rr2_count", obs_log.size(), base + 7);
    if (obs_log.size() >= base + 7) begin
      check("rr2_first", obs_log[base + 5], 3);
      check("rr2_second", obs_log[base + 6], 0);
    end
    repeat (6) step();

    // Backpressure
    rsp_ready = 1'b0;
    set_req(1, 1234, -5, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      step();
    end
    check("bp_valid", rsp_valid, 1);
    r_res = rsp_result; r_id = rsp_id;
    check("bp_result", r_res, 32'd1239);
    step();
    set_req(3, -7, -8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_result", rsp_result, r_res);
      check("bp_hold_id", rsp_id, r_id);
      check("bp_ready_low", req_ready, 0);
      step();
    end
    base = obs_log.size();
    rsp_ready = 1'b1;
    wait_grants(base + 1);
    check("bp_next_grant", (obs_log.size() > base) ? obs_log[base] : -1, 3);
    wait_rsp("bp_next", 32'hFFFF_FFF1, 3);

    // Withdrawal during RESP
    cnt1 = dut_rsp_cnt[1];
    rsp_ready = 1'b0;
    set_req(0, 5, 6, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      step();
    end
    step();
    set_req(1, 77, 1, 1'b0);
    step();
    req_valid[1] = 1'b0;
    step();
    rsp_ready = 1'b1;
    repeat (10) step();
    check("withdraw_no_rsp", dut_rsp_cnt[1], cnt1);

    // Reset while a job is in EXEC
    set_req(1, 9, 9, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_grant != '0) break;
    end
    #1 rst_n = 1'b0;
    set_req(0, 11, 1, 1'b0);
    set_req(1, 22, 2, 1'b1);
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_as", {as_op1, as_op2, as_mode}, 0);
    check("midrst_rsp", {rsp_result, rsp_id}, 0);
    check("midrst_ready", req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = obs_log.size();
    wait_grants(base + 2);
    check("midrst_count", obs_log.size(), base + 2);
    if (obs_log.size() >= base + 2) begin
      check("midrst_first", obs_log[base], 0);
      check("midrst_second", obs_log[base + 1], 1);
    end
    repeat (6) step();

    // Random traffic with backpressure and occasional withdrawal
    for (int c = 0; c < 600; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 4 == 0))
          set_req(i, int'($urandom), int'($urandom), 1'($urandom));
        else if (req_valid[i] && ($urandom % 16 == 0))
          req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom % 3) != 0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
